// File: rtl/hack_run_ctrl.sv
// Run-control and debug unit for the Hack Computer: owns the CPU reset and clock
// enable, and halts on breakpoints, cycle budget, tight end-loops or command.
module hack_run_ctrl #(
  parameter  int PC_WIDTH   = 15,
  parameter  int NUM_BP     = 4,
  parameter  int CNT_WIDTH  = 32,
  parameter  int RST_CYCLES = 2,
  parameter  int LOOP_COUNT = 4,
  localparam int BP_W       = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_op,
  input  logic [3:0]           cmd_idx,
  input  logic [CNT_WIDTH-1:0] cmd_arg,
  output logic                 cmd_ready,
  output logic                 cpu_reset,
  output logic                 cpu_en,
  output logic [2:0]           state,
  output logic [2:0]           halt_reason,
  output logic [BP_W-1:0]      bp_hit,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int LC_W = $clog2(LOOP_COUNT + 1);
  localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [LC_W-1:0] LOOP_MAX = LC_W'(LOOP_COUNT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_START      = 3'd1,
    OP_STOP       = 3'd2,
    OP_STEP       = 3'd3,
    OP_RESUME     = 3'd4,
    OP_SET_BP     = 3'd5,
    OP_CLR_BP     = 3'd6,
    OP_SET_BUDGET = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    R_NONE   = 3'd0,
    R_STOP   = 3'd1,
    R_BP     = 3'd2,
    R_BUDGET = 3'd3,
    R_LOOP   = 3'd4,
    R_STEP   = 3'd5
  } reason_e;

  state_e               state_q, state_d;
  logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_WIDTH-1:0] budget_q, budget_d;
  logic [LC_W-1:0]      loop_cnt_q, loop_cnt_d;
  logic [PC_WIDTH-1:0]  hist0_q, hist0_d, hist1_q, hist1_d;
  logic                 hv0_q, hv0_d, hv1_q, hv1_d;
  logic                 suppress_q, suppress_d;
  logic [2:0]           halt_reason_q, halt_reason_d;
  logic [BP_W-1:0]      bp_hit_q, bp_hit_d;

  logic                 bp_en_q   [NUM_BP];
  logic [PC_WIDTH-1:0]  bp_addr_q [NUM_BP];
  logic [NUM_BP-1:0]    bp_match;
  logic                 bp_any;
  logic [BP_W-1:0]      bp_idx;

  logic    cmd_go, op_start, op_stop, op_step, op_resume, op_set_budget, bp_wr;
  logic    start_go, resume_go, step_go;
  logic    bp_active, budget_hit, loop_hit, run_stop;
  reason_e stop_reason;

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_RUN);
  assign cmd_go    = cmd_valid && cmd_ready;

  assign op_start      = cmd_go && (cmd_op == OP_START);
  assign op_stop       = cmd_go && (cmd_op == OP_STOP);
  assign op_step       = cmd_go && (cmd_op == OP_STEP);
  assign op_resume     = cmd_go && (cmd_op == OP_RESUME);
  assign op_set_budget = cmd_go && (cmd_op == OP_SET_BUDGET);
  assign bp_wr         = cmd_go && ((cmd_op == OP_SET_BP) || (cmd_op == OP_CLR_BP));

  assign start_go  = op_start && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign resume_go = op_resume && (state_q == S_HALT);
  assign step_go   = op_step && (state_q == S_HALT);

  // Out-of-range indices never match any gi, so they fall through harmlessly.
  for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        bp_en_q[gi]   <= 1'b0;
        bp_addr_q[gi] <= '0;
      end else if (bp_wr && (cmd_idx == 4'(gi))) begin
        bp_en_q[gi]   <= (cmd_op == OP_SET_BP);
        bp_addr_q[gi] <= cmd_arg[PC_WIDTH-1:0];
      end
    end
    assign bp_match[gi] = bp_en_q[gi] && (bp_addr_q[gi] == pc);
  end

  always_comb begin
    bp_any = |bp_match;
    bp_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_match[i]) bp_idx = BP_W'(i);
    end
  end

  assign bp_active  = bp_any && !suppress_q;
  assign budget_hit = (budget_q != '0) && (cycle_count_q == budget_q);
  assign loop_hit   = (loop_cnt_q == LOOP_MAX);

  always_comb begin
    stop_reason = R_NONE;
    if (op_stop)         stop_reason = R_STOP;
    else if (bp_active)  stop_reason = R_BP;
    else if (budget_hit) stop_reason = R_BUDGET;
    else if (loop_hit)   stop_reason = R_LOOP;
  end

  assign run_stop = (state_q == S_RUN) && (stop_reason != R_NONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_go) state_d = S_RESET;
      S_RESET: if (rst_cnt_q == RST_LAST) state_d = S_RUN;
      S_RUN:   if (run_stop) state_d = S_HALT;
      S_STEP:  state_d = S_HALT;
      S_HALT: begin
        if (start_go)       state_d = S_RESET;
        else if (resume_go) state_d = S_RUN;
        else if (step_go)   state_d = S_STEP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_reset = (state_q == S_IDLE) || (state_q == S_RESET);
    cpu_en    = ((state_q == S_RUN) && !run_stop) || (state_q == S_STEP);
  end

  always_comb begin
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    budget_d      = budget_q;
    loop_cnt_d    = loop_cnt_q;
    hist0_d       = hist0_q;
    hist1_d       = hist1_q;
    hv0_d         = hv0_q;
    hv1_d         = hv1_q;
    suppress_d    = suppress_q;
    halt_reason_d = halt_reason_q;
    bp_hit_d      = bp_hit_q;

    if (op_set_budget) budget_d = cmd_arg;

    if (start_go) begin
      rst_cnt_d     = '0;
      cycle_count_d = '0;
      loop_cnt_d    = '0;
      hv0_d         = 1'b0;
      hv1_d         = 1'b0;
    end else begin
      if (state_q == S_RESET) rst_cnt_d = rst_cnt_q + RC_W'(1);
      if (cpu_en) begin
        if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
        // pc equal to the one two instructions back covers both 1- and 2-instruction loops.
        if (hv1_q && (pc == hist1_q)) begin
          if (loop_cnt_q != LOOP_MAX) loop_cnt_d = loop_cnt_q + LC_W'(1);
        end else begin
          loop_cnt_d = '0;
        end
        hist0_d = pc;
        hist1_d = hist0_q;
        hv0_d   = 1'b1;
        hv1_d   = hv0_q;
      end
    end

    if (resume_go)                          suppress_d = 1'b1;
    else if (start_go || state_q == S_RUN)  suppress_d = 1'b0;

    if (start_go || resume_go || step_go) begin
      halt_reason_d = R_NONE;
      bp_hit_d      = '0;
    end else if (run_stop) begin
      halt_reason_d = stop_reason;
      if (stop_reason == R_BP) bp_hit_d = bp_idx;
    end else if (state_q == S_STEP) begin
      halt_reason_d = R_STEP;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      budget_q      <= '0;
      loop_cnt_q    <= '0;
      hist0_q       <= '0;
      hist1_q       <= '0;
      hv0_q         <= 1'b0;
      hv1_q         <= 1'b0;
      suppress_q    <= 1'b0;
      halt_reason_q <= '0;
      bp_hit_q      <= '0;
    end else begin
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      budget_q      <= budget_d;
      loop_cnt_q    <= loop_cnt_d;
      hist0_q       <= hist0_d;
      hist1_q       <= hist1_d;
      hv0_q         <= hv0_d;
      hv1_q         <= hv1_d;
      suppress_q    <= suppress_d;
      halt_reason_q <= halt_reason_d;
      bp_hit_q      <= bp_hit_d;
    end
  end

  assign state       = state_q;
  assign halt_reason = halt_reason_q;
  assign bp_hit      = bp_hit_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_hack_run_ctrl.sv
// Scoreboard bench for hack_run_ctrl: stimulus queues expected snapshots and halt
// events; a monitor pops and compares them as the DUT presents them.
module tb_hack_run_ctrl;

  localparam logic [2:0] C_START = 3'd1, C_STOP = 3'd2, C_STEP = 3'd3, C_RESUME = 3'd4;
  localparam logic [2:0] C_SET_BP = 3'd5, C_CLR_BP = 3'd6, C_SET_BUDGET = 3'd7;

  logic        clk;
  logic        rst;
  logic [14:0] pc = '0;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        cmd_ready, cpu_reset, cpu_en;
  logic [2:0]  state, halt_reason;
  logic [1:0]  bp_hit;
  logic [31:0] cycle_count;

  hack_run_ctrl dut (
    .clock(clk), .reset(rst), .pc(pc),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
    .cmd_ready(cmd_ready), .cpu_reset(cpu_reset), .cpu_en(cpu_en), .state(state),
    .halt_reason(halt_reason), .bp_hit(bp_hit), .cycle_count(cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Minimal CPU: linear code, optionally ending in a 20/21 jump loop.
  logic loop_mode = 1'b0;
  always @(posedge clk) begin
    if (cpu_reset)   pc <= '0;
    else if (cpu_en) pc <= (loop_mode && pc == 15'd21) ? 15'd20 : pc + 15'd1;
  end

  typedef struct {
    string name; logic [2:0] st; logic rs; logic en; logic rdy;
    logic [2:0] hr; logic [1:0] bp; logic [31:0] cnt;
  } snap_t;
  typedef struct {
    string name; logic [2:0] hr; logic [1:0] bp; logic [31:0] cnt; logic [14:0] pcv; int pulses;
  } halt_t;

  snap_t snap_q[$];
  halt_t halt_q[$];
  snap_t s_cur;
  halt_t h_cur;
  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  logic [2:0] prev_state = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic snap(input string name, input logic [2:0] st, input logic rs, input logic en,
                      input logic rdy, input logic [2:0] hr, input logic [1:0] bp, input logic [31:0] cnt);
    snap_t s;
    s.name = name; s.st = st; s.rs = rs; s.en = en; s.rdy = rdy; s.hr = hr; s.bp = bp; s.cnt = cnt;
    snap_q.push_back(s);
  endtask

  task automatic expect_halt(input string name, input logic [2:0] hr, input logic [1:0] bp,
                             input logic [31:0] cnt, input logic [14:0] pcv, input int pulses);
    halt_t h;
    h.name = name; h.hr = hr; h.bp = bp; h.cnt = cnt; h.pcv = pcv; h.pulses = pulses;
    halt_q.push_back(h);
  endtask

  // Monitor: samples 1 time unit after each falling edge.
  always @(negedge clk) begin
    #1;
    if (cpu_reset)   en_cnt = 0;
    else if (cpu_en) en_cnt++;
    while (snap_q.size() > 0) begin
      s_cur = snap_q.pop_front();
      chk({s_cur.name, ".state"},       32'(state),       32'(s_cur.st));
      chk({s_cur.name, ".cpu_reset"},   32'(cpu_reset),   32'(s_cur.rs));
      chk({s_cur.name, ".cpu_en"},      32'(cpu_en),      32'(s_cur.en));
      chk({s_cur.name, ".cmd_ready"},   32'(cmd_ready),   32'(s_cur.rdy));
      chk({s_cur.name, ".halt_reason"}, 32'(halt_reason), 32'(s_cur.hr));
      chk({s_cur.name, ".bp_hit"},      32'(bp_hit),      32'(s_cur.bp));
      chk({s_cur.name, ".cycle_count"}, cycle_count,      s_cur.cnt);
    end
    if (state == 3'd4 && prev_state != 3'd4) begin
      if (halt_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_halt: actual reason %0d at pc %0d required no halt", halt_reason, pc);
      end else begin
        h_cur = halt_q.pop_front();
        $display("halt %s: reason %0d bp %0d count %0d pc %0d pulses %0d",
                 h_cur.name, halt_reason, bp_hit, cycle_count, pc, en_cnt);
        chk({h_cur.name, ".halt_reason"}, 32'(halt_reason), 32'(h_cur.hr));
        chk({h_cur.name, ".bp_hit"},      32'(bp_hit),      32'(h_cur.bp));
        chk({h_cur.name, ".cycle_count"}, cycle_count,      h_cur.cnt);
        chk({h_cur.name, ".pc"},          32'(pc),          32'(h_cur.pcv));
        chk({h_cur.name, ".en_pulses"},   32'(en_cnt),      32'(h_cur.pulses));
      end
    end
    prev_state = state;
  end

  // Called at a falling edge; the command is captured on the following rising edge.
  task automatic cmd(input logic [2:0] op, input logic [3:0] idx, input logic [31:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = '0; cmd_idx = '0; cmd_arg = '0;
  endtask

  task automatic wait_halt(input string name, input int maxc);
    int n = 0;
    while (state != 3'd4 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (state != 3'd4) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: actual state %0d required 4", name, state);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual time %0t required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_idx = '0; cmd_arg = '0;
    repeat (3) @(negedge clk);
    snap("reset_state", 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 32'd0);
    rst = 1'b0;

    cmd(C_STEP, 4'd0, 32'd0);
    cmd(C_RESUME, 4'd0, 32'd0);
    cmd(C_STOP, 4'd0, 32'd0);
    snap("idle_ignores", 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 32'd0);

    // START: two RESET cycles (with an ignored SET_BP), then RUN from pc 0.
    cmd(C_START, 4'd0, 32'd0);
    snap("reset_cycle1", 3'd1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    cmd(C_SET_BP, 4'd1, 32'd1);
    snap("reset_cycle2", 3'd1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0);
    @(negedge clk);
    snap("run_first", 3'd2, 1'b0, 1'b1, 1'b1, 3'd0, 2'd0, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      snap("run_count", 3'd2, 1'b0, 1'b1, 1'b1, 3'd0, 2'd0, 32'(k));
    end
    cmd(C_SET_BP, 4'd2, 32'd12);
    repeat (2) @(negedge clk);
    snap("pre_reset", 3'd2, 1'b0, 1'b1, 1'b1, 3'd0, 2'd0, 32'd6);
    @(negedge clk);
    rst = 1'b1;
    snap("mid_run_reset", 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Breakpoint, resume past it into a budget stop, then a single step.
    cmd(C_SET_BP, 4'd0, 32'd5);
    expect_halt("bp5", 3'd2, 2'd0, 32'd5, 15'd5, 5);
    cmd(C_START, 4'd0, 32'd0);
    wait_halt("bp5", 60);
    cmd(C_SET_BUDGET, 4'd0, 32'd8);
    expect_halt("resume_budget8", 3'd3, 2'd0, 32'd8, 15'd8, 8);
    cmd(C_RESUME, 4'd0, 32'd0);
    wait_halt("resume_budget8", 60);
    expect_halt("step", 3'd5, 2'd0, 32'd9, 15'd9, 9);
    cmd(C_STEP, 4'd0, 32'd0);
    wait_halt("step", 10);

    // Budget of 10, then breakpoint beating an equal budget.
    cmd(C_CLR_BP, 4'd0, 32'd0);
    cmd(C_SET_BUDGET, 4'd0, 32'd10);
    expect_halt("budget10", 3'd3, 2'd0, 32'd10, 15'd10, 10);
    cmd(C_START, 4'd0, 32'd0);
    wait_halt("budget10", 60);
    cmd(C_SET_BP, 4'd1, 32'd3);
    cmd(C_SET_BUDGET, 4'd0, 32'd3);
    expect_halt("bp_over_budget", 3'd2, 2'd1, 32'd3, 15'd3, 3);
    cmd(C_START, 4'd0, 32'd0);
    wait_halt("bp_over_budget", 60);

    // STOP coinciding with a breakpoint; out-of-range SET_BP must do nothing.
    cmd(C_SET_BUDGET, 4'd0, 32'd0);
    cmd(C_SET_BP, 4'd1, 32'd6);
    cmd(C_SET_BP, 4'd4, 32'd2);
    expect_halt("stop_over_bp", 3'd1, 2'd0, 32'd6, 15'd6, 6);
    cmd(C_START, 4'd0, 32'd0);
    n = 0;
    while (pc != 15'd6 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("stop_align_pc", 32'(pc), 32'd6);
    cmd(C_STOP, 4'd0, 32'd0);
    wait_halt("stop_over_bp", 10);

    // Program ending in a 20/21 jump loop.
    cmd(C_CLR_BP, 4'd1, 32'd0);
    loop_mode = 1'b1;
    expect_halt("end_loop", 3'd4, 2'd0, 32'd26, 15'd20, 26);
    cmd(C_START, 4'd0, 32'd0);
    wait_halt("end_loop", 200);

    repeat (2) @(negedge clk);
    chk("snap_queue_drained", 32'(snap_q.size()), 32'd0);
    chk("halt_queue_drained", 32'(halt_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_run_ctrl.md
Name: hack_run_ctrl

Overview:
- Parametrised run-control and debug unit placed between the board or bench and the Hack Computer.
- Gates the Computer's clock enable and drives its reset.
- Stops execution on programmable breakpoints, on a cycle budget, on a tight-loop (program-end) pattern, or on command; supports single-step.
- Replaces fixed-time stop and free-running simulation with deterministic, cycle-counted runs.

Parameters:
- PC_WIDTH, 15, width of the program counter and breakpoint addresses.
- NUM_BP, 4, number of breakpoint registers (1..16).
- CNT_WIDTH, 32, width of the cycle counter and budget.
- RST_CYCLES, 2, cycles cpu_reset is held on START (>=1).
- LOOP_COUNT, 4, consecutive loop matches that declare program end (>=1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pc  in  PC_WIDTH  Computer's current program counter.
- cmd_valid  in  1  command strobe; one command per asserted cycle.
- cmd_op  in  3  0 NOP, 1 START, 2 STOP, 3 STEP, 4 RESUME, 5 SET_BP, 6 CLR_BP, 7 SET_BUDGET.
- cmd_idx  in  4  breakpoint index for SET_BP/CLR_BP.
- cmd_arg  in  CNT_WIDTH  BP address (low PC_WIDTH bits) or budget.
- cmd_ready  out  1  high when state is IDLE or HALT or RUN; commands at cmd_ready=0 are ignored.
- cpu_reset  out  1  reset to the Computer.
- cpu_en  out  1  Computer clock enable.
- state  out  3  0 IDLE, 1 RESET, 2 RUN, 3 STEP, 4 HALT.
- halt_reason  out  3  0 none, 1 STOP, 2 breakpoint, 3 budget, 4 loop, 5 step done.
- bp_hit  out  log2(NUM_BP) (min 1)  index of the breakpoint that matched.
- cycle_count  out  CNT_WIDTH  enabled cycles since START.

Behaviour:
- Reset (async, active-high): state=IDLE, cpu_reset=1, cpu_en=0, halt_reason=0, bp_hit=0, cycle_count=0, all BPs disabled, budget=0.
- cpu_en is combinational: high only in RUN (unless a stop condition holds this cycle) and for the single STEP cycle. One enabled cycle = one instruction.
- IDLE: cpu_reset=1.
  - START -> RESET: clears cycle_count, loop counter and halt_reason.
  - SET_BP, CLR_BP and SET_BUDGET are also accepted here.
- RESET: cpu_reset=1 for exactly RST_CYCLES cycles, then RUN. cpu_reset=0 from the first RUN cycle.
- RUN: each cycle, stop conditions are evaluated on the current pc before the instruction executes. If any holds, cpu_en=0 that cycle, next state HALT.
  - Priority: STOP cmd (1) > breakpoint (2) > budget (3) > loop (4).
  - Breakpoint: pc equals an enabled BP address. Lowest matching index goes to bp_hit. Suppressed on the first RUN cycle after RESUME or STEP from HALT, so the CPU can leave the BP address.
  - Budget: budget!=0 and cycle_count==budget, so exactly `budget` instructions execute. budget=0 means unlimited.
  - Loop: a two-entry history holds pc of the previous enabled cycles. An enabled cycle with pc==history[1] increments the loop counter; any other enabled cycle clears it. Reaching LOOP_COUNT halts; this covers 1- and 2-instruction end loops.
  - Otherwise cpu_en=1 and cycle_count increments (saturating at all-ones).
- STEP (entered only from HALT): one enabled cycle, no stop checks, cycle_count increments, then HALT with halt_reason=5.
- HALT: cpu_en=0, cpu_reset=0; CPU state is preserved.
  - RESUME -> RUN.
  - STEP -> STEP.
  - START -> RESET.
  - STOP is a no-op.
- STOP in IDLE is a no-op. STEP or RESUME in IDLE is ignored.
- SET_BP or CLR_BP with cmd_idx>=NUM_BP is ignored. SET_BP/SET_BUDGET issued during RUN take effect next cycle.
- A command is acted on in the cycle it is presented (registered on that edge).
- halt_reason and bp_hit hold until the next START, RESUME or STEP.

Test Plan:
- Reset mid-RUN (after 7 cycles) -> same cycle: state=0, cpu_reset=1, cpu_en=0, cycle_count=0, BPs cleared.
- START with RST_CYCLES=2 -> cpu_reset high 2 cycles after the command edge, then cpu_en=1; pc 0,1,2 gives cycle_count 1,2,3.
- SET_BP idx0=5, START, linear code -> HALT with cpu_en=0 while pc=5, halt_reason=2, bp_hit=0, cycle_count=5. RESUME -> pc 5 executes, no re-hit. STEP -> one cycle, halt_reason=5, count+1.
- SET_BUDGET 10, START -> exactly 10 cpu_en pulses, halt_reason=3, cycle_count=10. BP=3 together with budget 3 -> halt at pc=3 with reason 2 (priority).
- Program ending in an `@END;0;JMP` loop at pc 20/21, LOOP_COUNT=4 -> HALT with halt_reason=4 after the 4th match.
- STOP and a BP match on the same cycle -> halt_reason=1. SET_BP idx=NUM_BP -> no effect. Commands while in RESET are ignored and cmd_ready=0.
